pc_gen: RTL

- Next-generation program-counter unit for the multi-cycle NPC core.
- Holds the architectural PC and computes the next PC: sequential, branch/jal, jalr, trap entry (mtvec) or mret (mepc).
- Presents the PC to the IFU over a valid/ready handshake, and advances only when the EXU/WBU signals instruction completion.
- Adds over the previous PC block: parametrised width, reset vector and step, jalr bit-0 clearing, misaligned-target trapping, and a retired-instruction counter.

---
 rtl/pc_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program-counter unit: holds the architectural PC, hands it to the IFU over
// valid/ready, and computes the next PC when the back end retires an instruction.
module pc_gen #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_VALUE  = 32'h80000000,
  parameter int               STEP       = 4,
  parameter int               ALIGN_BITS = 2,
  parameter int               CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  input  logic [1:0]       pc_sel,
  input  logic [1:0]       adder_sel,
  input  logic             upd_valid,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc,
  output logic             misalign_err,
  output logic [WIDTH-1:0] misalign_addr,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    WAIT  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             pc_valid_reg;
  logic             misalign_err_reg;
  logic [WIDTH-1:0] misalign_addr_reg;
  logic [CNT_W-1:0] retired_cnt_reg;

  logic [WIDTH-1:0] op_a, op_b, sum, target;
  logic             misaligned;
  logic             accept;

  // Shared adder: sequential step, branch/jal (pc+imm) and jalr (rs1+imm).
  always_comb begin
    op_a = adder_sel[1] ? rs1_data : pc_reg;
    op_b = adder_sel[0] ? imm : STEP_W;
    sum  = op_a + op_b;
    if (adder_sel == 2'b11) begin
      sum[0] = 1'b0;
    end
  end

  always_comb begin
    case (pc_sel)
      2'b01:   target = mtvec;
      2'b11:   target = mepc;
      default: target = sum;
    endcase
  end

  assign misaligned = |target[ALIGN_BITS-1:0];
  assign accept     = (state_reg == WAIT) && upd_valid;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BOOT:    state_next = FETCH;
      FETCH:   if (pc_ready) state_next = WAIT;
      WAIT:    if (upd_valid) state_next = FETCH;
      default: state_next = BOOT;
    endcase
    // A bad target diverts to mtvec, which is trusted and not checked again.
    if (accept) begin
      pc_next = misaligned ? mtvec : target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= BOOT;
      pc_reg            <= RST_VALUE;
      pc_valid_reg      <= 1'b0;
      misalign_err_reg  <= 1'b0;
      misalign_addr_reg <= '0;
      retired_cnt_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      // Registered from the next state so pc_ready never reaches pc_valid combinationally.
      pc_valid_reg     <= (state_next == FETCH);
      misalign_err_reg <= accept && misaligned;
      if (accept && misaligned) begin
        misalign_addr_reg <= target;
      end
      if (accept) begin
        retired_cnt_reg <= retired_cnt_reg + 1'b1;
      end
    end
  end

  assign pc            = pc_reg;
  assign pc_valid      = pc_valid_reg;
  assign misalign_err  = misalign_err_reg;
  assign misalign_addr = misalign_addr_reg;
  assign retired_cnt   = retired_cnt_reg;

endmodule
